// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_t;

    localparam int INST_BYTES = 4;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, keeps one imem request in flight at a time,
// hands instructions to decode and squashes work made stale by a redirect.
//
// state  | meaning
// S_IDLE | one settling cycle after reset
// S_REQ  | request for pc presented to imem
// S_WAIT | request accepted, waiting for the response (drop=1 discards it)
// S_HOLD | instruction presented to decode
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          N        = 64,
    parameter int          W        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect_valid,
    input  logic [N-1:0]     redirect_pc,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [N-1:0]     imem_req_addr,
    input  logic             imem_resp_valid,
    input  logic [W-1:0]     imem_resp_data,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [W-1:0]     inst_data,
    output logic [N-1:0]     inst_pc,
    output logic [CNT_W-1:0] fetch_count
);

    fetch_state_t     state_q, state_d;
    logic [N-1:0]     pc_q, pc_d;
    logic [N-1:0]     req_pc_q, req_pc_d;
    logic             drop_q, drop_d;
    logic [W-1:0]     inst_data_q, inst_data_d;
    logic [N-1:0]     inst_pc_q, inst_pc_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

    logic [N-1:0]     redirect_target;
    logic [N-1:0]     pc_incr;

    // Low address bits are forced to zero so the PC stays word aligned.
    assign redirect_target = redirect_pc & ~N'(INST_BYTES - 1);
    assign pc_incr         = pc_q + N'(INST_BYTES);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        drop_d        = drop_q;
        inst_data_d   = inst_data_q;
        inst_pc_d     = inst_pc_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
            end

            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                    if (redirect_valid) begin
                        pc_d   = redirect_target;
                        drop_d = 1'b1;
                    end else begin
                        req_pc_d = pc_q;
                        pc_d     = pc_incr;
                        drop_d   = 1'b0;
                    end
                end else if (redirect_valid) begin
                    pc_d = redirect_target;
                end
            end

            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (!drop_q && !redirect_valid) begin
                        inst_data_d = imem_resp_data;
                        inst_pc_d   = req_pc_q;
                        state_d     = S_HOLD;
                    end else begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                        if (redirect_valid) begin
                            pc_d = redirect_target;
                        end
                    end
                end else if (redirect_valid) begin
                    pc_d   = redirect_target;
                    drop_d = 1'b1;
                end
            end

            S_HOLD: begin
                // A squashed instruction is never counted, even if decode took it.
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    fetch_count_d = fetch_count_q + CNT_W'(1);
                    state_d       = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            drop_q        <= 1'b0;
            inst_data_q   <= '0;
            inst_pc_q     <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            drop_q        <= drop_d;
            inst_data_q   <= inst_data_d;
            inst_pc_q     <= inst_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == S_HOLD);
    assign inst_data      = inst_data_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: a latency-varying memory and a transaction-level
// model of the fetch stream (next pc, in-flight request, held instruction).
module tb_fetch_ctrl;

    localparam int N     = 64;
    localparam int W     = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             redirect_valid;
    logic [N-1:0]     redirect_pc;
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [N-1:0]     imem_req_addr;
    logic             imem_resp_valid;
    logic [W-1:0]     imem_resp_data;
    logic             inst_valid;
    logic             inst_ready;
    logic [W-1:0]     inst_data;
    logic [N-1:0]     inst_pc;
    logic [CNT_W-1:0] fetch_count;

    fetch_ctrl #(.N(N), .W(W), .RESET_PC('0), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    // Reference model of the fetch stream
    logic [N-1:0]     m_pc;
    logic             m_start;
    logic             m_out;
    logic [N-1:0]     m_out_addr;
    logic             m_out_dead;
    logic             m_hold;
    logic [N-1:0]     m_hold_pc;
    logic [W-1:0]     m_hold_data;
    logic [CNT_W-1:0] m_count;

    // Memory side
    logic [N-1:0]     mem_addr;
    int               mem_wait;
    logic             late_resp;

    task automatic reset_model();
        m_pc       = '0;
        m_start    = 1'b1;
        m_out      = 1'b0;
        m_out_addr = '0;
        m_out_dead = 1'b0;
        m_hold     = 1'b0;
        m_hold_pc  = '0;
        m_hold_data= '0;
        m_count    = '0;
        mem_addr   = '0;
        mem_wait   = 0;
    endtask

    function automatic logic [N-1:0] pick_target();
        logic [N-1:0] t;
        case ($urandom_range(0, 4))
            0:       t = 64'h1000;
            1:       t = 64'h2003;
            2:       t = 64'h40;
            3:       t = 64'hFFFF_FFFF_FFFF_FFF0 | N'($urandom_range(0, 15));
            default: t = {$urandom, $urandom};
        endcase
        return t;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req_valid"},  imem_req_valid, 0);
        check_val({tag, "_req_addr"},   imem_req_addr,  0);
        check_val({tag, "_inst_valid"}, inst_valid,     0);
        check_val({tag, "_inst_data"},  inst_data,      0);
        check_val({tag, "_inst_pc"},    inst_pc,        0);
        check_val({tag, "_count"},      fetch_count,    0);
    endtask

    // Entered and left on a falling edge: check, drive, advance model, wait one cycle.
    task automatic run_cycles(input int n, input int p_redir, input int p_rdy,
                              input int p_irdy, input int max_lat);
        logic exp_rv, acc, rd, rsp;
        logic [N-1:0] tgt;
        for (int c = 0; c < n; c++) begin
            exp_rv = !m_start && !m_out && !m_hold;
            check_val("req_valid", imem_req_valid, exp_rv);
            if (exp_rv) check_val("req_addr", imem_req_addr, m_pc);
            check_val("inst_valid", inst_valid, m_hold);
            if (m_hold) begin
                check_val("inst_pc",   inst_pc,   m_hold_pc);
                check_val("inst_data", inst_data, m_hold_data);
            end
            check_val("fetch_count", fetch_count, m_count);

            rd  = ($urandom_range(0, 99) < p_redir);
            tgt = pick_target();
            redirect_valid = rd;
            redirect_pc    = tgt;
            imem_req_ready = ($urandom_range(0, 99) < p_rdy);
            inst_ready     = ($urandom_range(0, 99) < p_irdy);
            if (m_out) begin
                rsp = (mem_wait == 0);
                if (mem_wait > 0) mem_wait--;
            end else begin
                rsp = ($urandom_range(0, 99) < 5);
            end
            if (late_resp) begin
                rsp       = 1'b1;
                late_resp = 1'b0;
            end
            imem_resp_valid = rsp;
            imem_resp_data  = rsp ? mem_fn(mem_addr) : W'($urandom);

            acc = exp_rv && imem_req_ready;
            if (acc) begin
                mem_addr = imem_req_addr;
                mem_wait = $urandom_range(1, max_lat) - 1;
            end

            if (m_start) begin
                m_start = 1'b0;
            end else if (acc) begin
                m_out      = 1'b1;
                m_out_addr = m_pc;
                m_out_dead = rd;
            end else if (m_out && rsp) begin
                m_out = 1'b0;
                if (!m_out_dead && !rd) begin
                    m_hold      = 1'b1;
                    m_hold_pc   = m_out_addr;
                    m_hold_data = mem_fn(m_out_addr);
                end
            end else if (m_out && rd) begin
                m_out_dead = 1'b1;
            end else if (m_hold) begin
                if (rd) begin
                    m_hold = 1'b0;
                end else if (inst_ready) begin
                    m_hold  = 1'b0;
                    m_count = m_count + 1'b1;
                end
            end

            if (rd)       m_pc = tgt & ~N'(3);
            else if (acc) m_pc = m_pc + N'(4);

            @(negedge clk);
        end
    endtask

    initial begin
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        inst_ready      = 1'b0;
        late_resp       = 1'b0;
        reset_model();

        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // Streaming with an ideal memory, then increasingly hostile mixes.
        run_cycles(20,  0, 100, 100, 1);
        run_cycles(600, 5,  70,  60, 4);
        run_cycles(400, 30, 50,  50, 3);

        for (int k = 0; k < 50 && !m_out; k++) run_cycles(1, 5, 80, 80, 4);
        check_val("reach_wait", m_out, 1);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_wait");
        @(negedge clk);
        check_reset_outputs("rst_hold");
        reset_model();
        late_resp = 1'b1;
        reset     = 1'b0;

        run_cycles(400, 10, 70, 70, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
